// File: rtl/matrix_pkg.sv
// Purpose: shared types and sizes for the dot-matrix column feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a; the feeder free-runs and has no ready input.
package matrix_pkg;

  localparam int COL_AW  = 5;             // bitmap column address width
  localparam int ROW_W   = 16;            // bits per column (one per row)
  localparam int NCOLS   = 1 << COL_AW;   // bitmap columns
  localparam int WIN_MAX = 16;            // widest window the driver accepts

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_COL,
    HOLD_COL,
    FRAME_END
  } state_t;

endpackage

// File: rtl/matrix_column_feeder_if.sv
// Purpose: host-side bitmap write/control and driver-side column strobes, bundled.
// Latency: n/a (wires only).
// Backpressure: none; the driver takes every LOAD and IN_CLR strobe as issued.
// Ports: master = host/driver side (drives writes and controls, sees strobes);
//        slave  = feeder (takes writes and controls, drives strobes).
interface matrix_column_feeder_if;

  logic                           wr_en;
  logic [matrix_pkg::COL_AW-1:0]  wr_addr;
  logic [matrix_pkg::ROW_W-1:0]   wr_data;
  logic                           run;
  logic                           clear_req;
  logic                           scroll_en;
  logic [matrix_pkg::COL_AW-1:0]  column_id;
  logic [matrix_pkg::ROW_W-1:0]   in_column;
  logic                           LOAD;
  logic                           IN_CLR;
  logic                           busy;
  logic                           frame_done;

  modport master (
    output wr_en, wr_addr, wr_data, run, clear_req, scroll_en,
    input  column_id, in_column, LOAD, IN_CLR, busy, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, run, clear_req, scroll_en,
    output column_id, in_column, LOAD, IN_CLR, busy, frame_done
  );

endinterface

// File: rtl/matrix_col_ram.sv
// Purpose: NCOLS x ROW_W bitmap store; sync write, async read, async clear.
// Latency: write visible to reads the cycle after the write edge; read is combinational.
// Backpressure: none; a write is accepted every cycle wr_en is high.
// Ports: clk, rst_n (async active-low clear), wr_en/wr_addr/wr_data, rd_addr -> rd_data.
module matrix_col_ram
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [COL_AW-1:0] wr_addr,
  input  logic [ROW_W-1:0]  wr_data,
  input  logic [COL_AW-1:0] rd_addr,
  output logic [ROW_W-1:0]  rd_data
);

  logic [ROW_W-1:0] mem [NCOLS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOLS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A reader that registers rd_data on the same edge as a write sees the old word.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/matrix_column_feeder.sv
// Purpose: sends a WIN-column window of the bitmap to the matrix driver, one column per HOLD-cycle slot.
// Latency: first LOAD one cycle after run is sampled (two with clear); frame = WIN*HOLD+1 cycles (+1 with clear).
// Backpressure: none; frames repeat back-to-back while run is high.
// Ports: CLK, RESET (async active-low); bus.slave carries bitmap writes, run/clear_req/scroll_en,
//        and the registered strobes column_id/in_column/LOAD/IN_CLR/busy/frame_done.
module matrix_column_feeder
  import matrix_pkg::*;
#(
  parameter int WIN  = WIN_MAX,
  parameter int HOLD = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  matrix_column_feeder_if.slave bus
);

  // Hold counter runs 0..HOLD-2 so HOLD_COL lasts HOLD-1 cycles.
  localparam int HCW = (HOLD > 2) ? $clog2(HOLD - 1) : 1;

  state_t            state, state_n;
  logic [COL_AW-1:0] col, col_n;
  logic [COL_AW-1:0] frame_off, frame_off_n;
  logic [COL_AW-1:0] offset, offset_n;
  logic [HCW-1:0]    hold_cnt, hold_cnt_n;
  logic [COL_AW-1:0] rd_addr;
  logic [ROW_W-1:0]  rd_data;

  matrix_col_ram u_ram (
    .clk     (CLK),
    .rst_n   (RESET),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_n     = state;
    col_n       = col;
    frame_off_n = frame_off;
    offset_n    = offset;
    hold_cnt_n  = hold_cnt;
    case (state)
      IDLE: begin
        if (bus.run) begin
          frame_off_n = offset;
          col_n       = '0;
          state_n     = bus.clear_req ? CLEAR : LOAD_COL;
        end
      end
      CLEAR: state_n = LOAD_COL;
      LOAD_COL: begin
        hold_cnt_n = '0;
        state_n    = HOLD_COL;
      end
      HOLD_COL: begin
        if (hold_cnt == HCW'(HOLD - 2)) begin
          if (col == COL_AW'(WIN - 1)) begin
            state_n = FRAME_END;
          end else begin
            col_n   = col + 1'b1;
            state_n = LOAD_COL;
          end
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      FRAME_END: begin
        if (bus.scroll_en) begin
          offset_n = offset + 1'b1;
        end
        // The next frame latches the post-scroll offset, so scrolling takes
        // effect on frame boundaries only.
        if (bus.run) begin
          frame_off_n = offset_n;
          col_n       = '0;
          state_n     = bus.clear_req ? CLEAR : LOAD_COL;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Column data is fetched for the slot being entered, so the captured word
  // predates any write landing on the same edge.
  assign rd_addr = frame_off_n + col_n;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      col       <= '0;
      frame_off <= '0;
      offset    <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      frame_off <= frame_off_n;
      offset    <= offset_n;
      hold_cnt  <= hold_cnt_n;
    end
  end

  // Strobes are registered from the next state so each is high exactly
  // while the FSM sits in the matching state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bus.LOAD       <= 1'b0;
      bus.IN_CLR     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.column_id  <= '0;
      bus.in_column  <= '0;
    end else begin
      bus.LOAD       <= (state_n == LOAD_COL);
      bus.IN_CLR     <= (state_n == CLEAR);
      bus.busy       <= (state_n != IDLE);
      bus.frame_done <= (state_n == FRAME_END);
      if (state_n == LOAD_COL) begin
        bus.column_id <= col_n;
        bus.in_column <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_column_feeder.sv
// Purpose: directed self-checking bench for matrix_column_feeder with a bitmap reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_matrix_column_feeder;

  localparam int WIN  = 16;
  localparam int HOLD = 4;

  typedef struct {
    string      tag;
    logic       clr;
    logic [1:0] drop;    // bit0: drop run, bit1: drop scroll_en after frame start
    logic [4:0] off;     // expected window offset
    int         wr_col;  // column whose capture edge gets a colliding write, -1 none
    int         period;  // expected cycles since previous frame start, 0 unchecked
  } frame_vec_t;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   n_wait;
  int   start;
  int   prev_start;
  logic [15:0] model [32];
  frame_vec_t  frame_tab [5];

  matrix_column_feeder_if bus ();

  matrix_column_feeder #(.WIN(WIN), .HOLD(HOLD)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {7'd0, bus.LOAD, bus.IN_CLR, bus.busy, bus.frame_done, bus.column_id, bus.in_column};
  endfunction

  task automatic write_bitmap(input logic [15:0] base);
    for (int k = 0; k < 32; k++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'(k);
      bus.wr_data = base + 16'(k);
      model[k]    = base + 16'(k);
      @(negedge CLK);
    end
    bus.wr_en = 1'b0;
  endtask

  // Called at a negedge with run already set; returns at the frame_done cycle.
  task automatic check_frame(input logic [4:0] off, input logic clr, input logic [1:0] drop,
                             input int wr_col, input string tag, output int start_cyc);
    int         n;
    logic [4:0] a;
    logic       gap_bad;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (drop[0]) bus.run = 1'b0;
      if (drop[1]) bus.scroll_en = 1'b0;
    end while (!(bus.IN_CLR || bus.LOAD) && n < 300);
    start_cyc = cyc;
    check({tag, "_start_latency"}, n, 1);
    if (!(bus.IN_CLR || bus.LOAD)) return;
    if (clr) begin
      check({tag, "_clr"}, {bus.IN_CLR, bus.LOAD}, 2'b10);
      @(negedge CLK);
    end
    for (int i = 0; i < WIN; i++) begin
      if (i > 0) begin
        gap_bad = 1'b0;
        for (int k = 0; k < HOLD - 1; k++) begin
          @(negedge CLK);
          gap_bad |= bus.LOAD | bus.IN_CLR | !bus.busy;
          if (i == wr_col && k == HOLD - 2) begin
            // Write lands on the very edge that captures column i.
            bus.wr_en   = 1'b1;
            bus.wr_addr = off + 5'(i);
            bus.wr_data = 16'hFFFF;
          end
        end
        check({tag, "_gap"}, gap_bad, 0);
        @(negedge CLK);
        bus.wr_en = 1'b0;
      end
      a = off + 5'(i);
      check({tag, "_col"}, {bus.LOAD, bus.IN_CLR, bus.column_id, bus.in_column},
            {1'b1, 1'b0, 5'(i), model[a]});
      if (i == wr_col) model[a] = 16'hFFFF;
    end
    gap_bad = 1'b0;
    for (int k = 0; k < HOLD - 1; k++) begin
      @(negedge CLK);
      gap_bad |= bus.LOAD | bus.frame_done;
    end
    check({tag, "_last_hold"}, gap_bad, 0);
    @(negedge CLK);
    check({tag, "_frame_done"}, {bus.frame_done, bus.busy, bus.LOAD}, 3'b110);
  endtask

  initial begin
    frame_tab[0] = '{"single",        1'b0, 2'b01, 5'd0, -1, 0};
    frame_tab[1] = '{"collide",       1'b0, 2'b01, 5'd0,  5, 0};
    frame_tab[2] = '{"after_collide", 1'b0, 2'b01, 5'd0, -1, 0};
    frame_tab[3] = '{"clr_a",         1'b1, 2'b00, 5'd0, -1, 0};
    frame_tab[4] = '{"clr_b",         1'b1, 2'b01, 5'd0, -1, 66};

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.run = 1'b0; bus.clear_req = 1'b0; bus.scroll_en = 1'b0;

    // Reset and idle
    #2 RESET = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      check("rst_outs", outs(), 0);
    end
    RESET = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      check("idle_outs", outs(), 0);
    end

    write_bitmap(16'h0100);

    // Table-driven frames
    prev_start = 0;
    for (int e = 0; e < 5; e++) begin
      bus.clear_req = frame_tab[e].clr;
      bus.run       = 1'b1;
      check_frame(frame_tab[e].off, frame_tab[e].clr, frame_tab[e].drop,
                  frame_tab[e].wr_col, frame_tab[e].tag, start);
      if (frame_tab[e].period != 0)
        check({frame_tab[e].tag, "_period"}, start - prev_start, frame_tab[e].period);
      prev_start = start;
      if (frame_tab[e].drop[0]) begin
        @(negedge CLK);
        check({frame_tab[e].tag, "_idle_after"},
              {bus.busy, bus.frame_done, bus.LOAD, bus.IN_CLR}, 0);
      end
    end
    bus.clear_req = 1'b0;

    // Scroll across the wrap: frame f uses offset f; the last frame drops scroll.
    bus.scroll_en = 1'b1;
    bus.run       = 1'b1;
    for (int f = 0; f < 31; f++) begin
      check_frame(5'(f), 1'b0, 2'b00, -1, "scroll", start);
    end
    check_frame(5'd31, 1'b0, 2'b11, -1, "scroll_last", start);
    @(negedge CLK);
    check("scroll_idle_after", bus.busy, 0);

    // Reset in the hold of column 7
    bus.run = 1'b1;
    n_wait  = 0;
    do begin
      @(negedge CLK);
      n_wait++;
    end while (!(bus.LOAD && bus.column_id == 5'd7) && n_wait < 300);
    check("rst_pre_col7", {bus.LOAD, bus.column_id}, {1'b1, 5'd7});
    @(negedge CLK);
    check("rst_pre_busy", bus.busy, 1);
    #2 RESET = 1'b0;
    #1 check("rst_async_outs", outs(), 0);
    @(negedge CLK);
    check("rst_hold_outs", outs(), 0);
    for (int k = 0; k < 32; k++) model[k] = 16'h0000;
    RESET = 1'b1;
    check_frame(5'd0, 1'b0, 2'b01, -1, "post_rst", start);
    @(negedge CLK);
    check("post_rst_idle", bus.busy, 0);

    // Offset must be back to 0 (it was 31 before reset).
    write_bitmap(16'hA500);
    bus.run = 1'b1;
    check_frame(5'd0, 1'b0, 2'b01, -1, "rst_off0", start);
    @(negedge CLK);
    check("rst_off0_idle", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
